// File: rtl/load_dcache_pkg.sv
// Shared field widths, FSM encoding and address-split helpers for the load path.
package load_dcache_pkg;
  localparam int WORD_SIZE   = 32;
  localparam int INDEX_BITS  = 4;
  localparam int OFFSET_BITS = 2;
  localparam int TAG_BITS    = WORD_SIZE - INDEX_BITS - OFFSET_BITS;
  localparam int LINES       = 1 << INDEX_BITS;
  localparam int WORDS       = 1 << OFFSET_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_REFILL, S_RESP, S_STORE
  } dc_state_e;

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [WORD_SIZE-1:0] a);
    return a[WORD_SIZE-1 -: TAG_BITS];
  endfunction

  function automatic logic [INDEX_BITS-1:0] addr_index(input logic [WORD_SIZE-1:0] a);
    return a[OFFSET_BITS +: INDEX_BITS];
  endfunction

  function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [WORD_SIZE-1:0] a);
    return a[OFFSET_BITS-1:0];
  endfunction
endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage: one combinational read port, one word write port,
// a line-fill strobe that marks a line valid, and a synchronous invalidate-all.
module dcache_array import load_dcache_pkg::*; (
  input  logic                   clk,
  input  logic                   clear,
  input  logic [INDEX_BITS-1:0]  rd_index,
  input  logic [OFFSET_BITS-1:0] rd_offset,
  output logic                   rd_valid,
  output logic [TAG_BITS-1:0]    rd_tag,
  output logic [WORD_SIZE-1:0]   rd_word,
  input  logic                   wr_en,
  input  logic [INDEX_BITS-1:0]  wr_index,
  input  logic [OFFSET_BITS-1:0] wr_offset,
  input  logic [WORD_SIZE-1:0]   wr_data,
  input  logic                   fill_en,
  input  logic [INDEX_BITS-1:0]  fill_index,
  input  logic [TAG_BITS-1:0]    fill_tag
);
  logic [LINES-1:0]     valid;
  logic [TAG_BITS-1:0]  tags [LINES];
  logic [WORD_SIZE-1:0] data [LINES][WORDS];

  // clear wins over a fill landing in the same cycle, so an aborted refill stays invalid
  always_ff @(posedge clk) begin
    if (clear)        valid <= '0;
    else if (fill_en) valid[fill_index] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en)   data[wr_index][wr_offset] <= wr_data;
    if (fill_en) tags[fill_index] <= fill_tag;
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_word  = data[rd_index][rd_offset];
endmodule

// File: rtl/load_dcache.sv
// Direct-mapped write-through load cache: loads hit/refill, committed stores
// are written through to memory and update the line only when it is present.
module load_dcache import load_dcache_pkg::*; (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 c_read_enable,
  input  logic [WORD_SIZE-1:0] c_ptr,
  output logic [WORD_SIZE-1:0] c_out,
  output logic                 c_hit,
  output logic                 c_ready,
  input  logic                 st_enable,
  input  logic [WORD_SIZE-1:0] st_addr,
  input  logic [WORD_SIZE-1:0] st_data,
  output logic                 st_done,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic                 mem_rvalid,
  input  logic [WORD_SIZE-1:0] mem_rdata
);
  dc_state_e state, state_nx;
  logic [WORD_SIZE-1:0]   req_addr, rd_addr;
  logic [OFFSET_BITS-1:0] beat;
  logic                   rd_valid, hit;
  logic [TAG_BITS-1:0]    rd_tag;
  logic [WORD_SIZE-1:0]   rd_word;
  logic                   wr_en, fill_en;
  logic [INDEX_BITS-1:0]  wr_index;
  logic [OFFSET_BITS-1:0] wr_offset;
  logic [WORD_SIZE-1:0]   wr_data;

  // the single read port looks at the latched store address while storing
  assign rd_addr = (state == S_STORE) ? mem_addr : req_addr;
  assign hit     = rd_valid && (rd_tag == addr_tag(rd_addr));

  dcache_array u_array (
    .clk        (clk),
    .clear      (reset),
    .rd_index   (addr_index(rd_addr)),
    .rd_offset  (addr_offset(rd_addr)),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_word    (rd_word),
    .wr_en      (wr_en),
    .wr_index   (wr_index),
    .wr_offset  (wr_offset),
    .wr_data    (wr_data),
    .fill_en    (fill_en),
    .fill_index (addr_index(req_addr)),
    .fill_tag   (addr_tag(req_addr))
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    wr_en     = 1'b0;
    fill_en   = 1'b0;
    wr_index  = addr_index(req_addr);
    wr_offset = beat;
    wr_data   = mem_rdata;
    case (state)
      S_IDLE: begin
        if (st_enable)          state_nx = S_STORE;
        else if (c_read_enable) state_nx = S_LOOKUP;
      end
      S_LOOKUP: state_nx = hit ? S_IDLE : S_REFILL;
      S_REFILL: begin
        if (mem_rvalid) begin
          wr_en = 1'b1;
          if (&beat) begin
            fill_en  = 1'b1;
            state_nx = S_RESP;
          end
        end
      end
      S_RESP: state_nx = S_IDLE;
      S_STORE: begin
        // rewriting the same word each cycle is idempotent while waiting for ack
        if (hit) begin
          wr_en     = 1'b1;
          wr_index  = addr_index(mem_addr);
          wr_offset = addr_offset(mem_addr);
          wr_data   = mem_wdata;
        end
        if (mem_ack) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_ready   <= 1'b0;
      c_hit     <= 1'b0;
      c_out     <= '0;
      st_done   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      req_addr  <= '0;
      beat      <= '0;
    end else begin
      c_ready <= 1'b0;
      st_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (st_enable) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= st_addr;
            mem_wdata <= st_data;
          end else if (c_read_enable) begin
            req_addr <= c_ptr;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            c_ready <= 1'b1;
            c_hit   <= 1'b1;
            c_out   <= rd_word;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {req_addr[WORD_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            beat     <= '0;
          end
        end
        S_REFILL: begin
          if (mem_ack)    mem_req <= 1'b0;
          if (mem_rvalid) beat <= beat + 1'b1;
        end
        S_RESP: begin
          c_ready <= 1'b1;
          c_hit   <= 1'b0;
          c_out   <= rd_word;
        end
        S_STORE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            st_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
